// File: rtl/bcd_down_cnt9999.sv
// bcd_down_cnt9999
// Four-digit BCD down-counter with preset load and a run/stop controller.
// A BCD preset is loaded in IDLE, `start` enters RUN, and each `ce` tick
// decrements the count by one. Expiry is flagged by a combinational
// borrow-out (`tc`) in the final `ce` cycle and a registered one-cycle
// `done` pulse on the following cycle. The count never wraps below 0000.
//
// Optional feature macro: BCD_DOWN_AUTO_RELOAD_EN
//   When defined, every accepted load is also captured in a reload register.
//   On expiry the count is reloaded from it and counting resumes, so only
//   `stop` or `clr` returns the block to IDLE.
//
// Ports:
//   clk   in   rising-edge clock
//   clr   in   synchronous active-high reset (top priority)
//   ce    in   count-enable tick (effective in RUN only)
//   load  in   load `din` (IDLE only; rejected when any nibble > 9)
//   din   in   [15:0] BCD preset, [15:12] thousands .. [3:0] units
//   start in   begin countdown (IDLE only, ignored when count is 0000)
//   stop  in   abort countdown, hold count, return to IDLE
//   qout  out  [15:0] current BCD count
//   tc    out  combinational borrow-out: RUN & ce & count == 0001
//   busy  out  registered, high while in RUN
//   done  out  registered, high for the single DONE cycle
//   err   out  registered one-cycle pulse after a rejected load
module bcd_down_cnt9999 (
  input  logic        clk,
  input  logic        clr,
  input  logic        ce,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] qout,
  output logic        tc,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q;
  logic        done_q;
  logic        err_q, err_d;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
  logic [15:0] reload_q, reload_d;
`endif

  // True when every nibble is a legal BCD digit.
  function automatic logic is_bcd(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // BCD decrement by one; a borrow turns a 0 digit into 9 and ripples up.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A load always wins over a simultaneous start.
        if (load) begin
          if (is_bcd(din)) begin
            cnt_d = din;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            reload_d = din;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (start && (cnt_q != '0)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (ce && (cnt_q != '0)) begin
          cnt_d = bcd_dec(cnt_q);
          if (cnt_q == 16'h0001) state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        // A zero reload value would never expire again, so it parks in IDLE.
        if (stop || (reload_q == '0)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = reload_q;
          state_d = S_RUN;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign qout = cnt_q;
  assign tc   = (state_q == S_RUN) && ce && (cnt_q == 16'h0001);
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_down_cnt9999.sv
// Testbench for bcd_down_cnt9999: directed cycle-by-cycle stimulus pushes the
// expected outputs for each cycle into a scoreboard queue; an independent
// monitor samples the DUT on the falling edge and checks against it.
module tb_bcd_down_cnt9999;

  logic        clk = 1'b0;
  logic        clr, ce, load, start, stop;
  logic [15:0] din;
  logic [15:0] qout;
  logic        tc, busy, done, err;

  typedef struct {
    int          cyc;
    logic [15:0] q;
    logic        tc;
    logic        busy;
    logic        done;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  bcd_down_cnt9999 dut (
    .clk  (clk),
    .clr  (clr),
    .ce   (ce),
    .load (load),
    .din  (din),
    .start(start),
    .stop (stop),
    .qout (qout),
    .tc   (tc),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every falling edge, check all expectations queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (qout !== e.q || tc !== e.tc || busy !== e.busy ||
                   done !== e.done || err !== e.err) begin
        n_fail++;
        $display("FAIL %s: got qout=%h tc=%b busy=%b done=%b err=%b, expected qout=%h tc=%b busy=%b done=%b err=%b",
                 e.name, qout, tc, busy, done, err, e.q, e.tc, e.busy, e.done, e.err);
      end
    end
  end

  task automatic set_in(input logic c, input logic e, input logic l,
                        input logic [15:0] d, input logic s, input logic p);
    clr = c; ce = e; load = l; din = d; start = s; stop = p;
  endtask

  // Expected outputs during the current cycle (with the inputs already set).
  task automatic expect_now(input logic [15:0] q, input logic t, input logic b,
                            input logic dn, input logic er, input string nm);
    exp_t e;
    e.cyc = cyc; e.q = q; e.tc = t; e.busy = b; e.done = dn; e.err = er; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef BCD_DOWN_AUTO_RELOAD_EN
  task automatic run_tests();
    set_in(1, 0, 0, 16'h0000, 0, 0); tick();
    set_in(0, 0, 1, 16'h0003, 0, 0); expect_now(16'h0000, 0, 0, 0, 0, "reset"); tick();
    set_in(0, 1, 0, 16'h0000, 1, 0); expect_now(16'h0003, 0, 0, 0, 0, "load3"); tick();
    set_in(0, 1, 0, 16'h0000, 0, 0);
    for (int r = 0; r < 2; r++) begin
      expect_now(16'h0003, 0, 1, 0, 0, "ar_q3"); tick();
      expect_now(16'h0002, 0, 1, 0, 0, "ar_q2"); tick();
      expect_now(16'h0001, 1, 1, 0, 0, "ar_tc"); tick();
      if (r == 1) set_in(0, 1, 0, 16'h0000, 0, 1);
      expect_now(16'h0000, 0, 0, 1, 0, "ar_done"); tick();
    end
    set_in(0, 1, 0, 16'h0000, 0, 0);
    expect_now(16'h0000, 0, 0, 0, 0, "ar_stop_idle"); tick();
    expect_now(16'h0000, 0, 0, 0, 0, "ar_stays_idle"); tick();
  endtask
`else
  task automatic run_tests();
    logic [15:0] seq12 [12];
    seq12 = '{16'h0012, 16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007,
              16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};

    set_in(1, 0, 0, 16'h0000, 0, 0); tick();
    set_in(0, 0, 1, 16'h0012, 0, 0); expect_now(16'h0000, 0, 0, 0, 0, "reset"); tick();
    set_in(0, 1, 0, 16'h0000, 1, 0); expect_now(16'h0012, 0, 0, 0, 0, "load12"); tick();
    set_in(0, 1, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 12; i++) begin
      expect_now(seq12[i], seq12[i] == 16'h0001, 1, 0, 0, "count12"); tick();
    end
    expect_now(16'h0000, 0, 0, 1, 0, "done12"); tick();
    set_in(0, 0, 1, 16'h1000, 0, 0); expect_now(16'h0000, 0, 0, 0, 0, "idle_after_done"); tick();
    // Borrow ripple
    set_in(0, 0, 0, 16'h0000, 1, 0); expect_now(16'h1000, 0, 0, 0, 0, "load1000"); tick();
    set_in(0, 1, 0, 16'h0000, 0, 0); expect_now(16'h1000, 0, 1, 0, 0, "run1000"); tick();
    set_in(0, 1, 0, 16'h0000, 0, 1); expect_now(16'h0999, 0, 1, 0, 0, "borrow"); tick();
    // Stop priority at 0005
    set_in(0, 0, 1, 16'h0007, 0, 0); expect_now(16'h0999, 0, 0, 0, 0, "stopped999"); tick();
    set_in(0, 0, 0, 16'h0000, 1, 0); expect_now(16'h0007, 0, 0, 0, 0, "load7"); tick();
    set_in(0, 1, 0, 16'h0000, 0, 0); expect_now(16'h0007, 0, 1, 0, 0, "run7"); tick();
    expect_now(16'h0006, 0, 1, 0, 0, "dec6"); tick();
    set_in(0, 1, 0, 16'h0000, 0, 1); expect_now(16'h0005, 0, 1, 0, 0, "at5"); tick();
    set_in(0, 0, 0, 16'h0000, 1, 0); expect_now(16'h0005, 0, 0, 0, 0, "stop_prio"); tick();
    set_in(0, 0, 0, 16'h0000, 0, 1); expect_now(16'h0005, 0, 1, 0, 0, "resume5"); tick();
    // Invalid load
    set_in(0, 0, 1, 16'h12A4, 0, 0); expect_now(16'h0005, 0, 0, 0, 0, "idle5"); tick();
    set_in(0, 0, 1, 16'h9999, 0, 0); expect_now(16'h0005, 0, 0, 0, 1, "bad_load"); tick();
    set_in(0, 0, 0, 16'h0000, 0, 0); expect_now(16'h9999, 0, 0, 0, 0, "load9999"); tick();
    // Start with count 0000
    set_in(0, 0, 1, 16'h0000, 0, 0); expect_now(16'h9999, 0, 0, 0, 0, "hold9999"); tick();
    set_in(0, 0, 0, 16'h0000, 1, 0); expect_now(16'h0000, 0, 0, 0, 0, "load0"); tick();
    // Load and start together: load wins
    set_in(0, 0, 1, 16'h0437, 1, 0); expect_now(16'h0000, 0, 0, 0, 0, "start_at0"); tick();
    set_in(0, 0, 0, 16'h0000, 1, 0); expect_now(16'h0437, 0, 0, 0, 0, "load_start"); tick();
    // Reset mid-RUN
    set_in(1, 1, 0, 16'h0000, 0, 0); expect_now(16'h0437, 0, 1, 0, 0, "run437"); tick();
    set_in(0, 0, 1, 16'h0002, 0, 0); expect_now(16'h0000, 0, 0, 0, 0, "clr_mid_run"); tick();
    // ce in IDLE, load in RUN, tc gated by ce
    set_in(0, 1, 0, 16'h0000, 0, 0); expect_now(16'h0002, 0, 0, 0, 0, "load2"); tick();
    set_in(0, 0, 0, 16'h0000, 1, 0); expect_now(16'h0002, 0, 0, 0, 0, "idle_ce"); tick();
    set_in(0, 1, 1, 16'h0050, 0, 0); expect_now(16'h0002, 0, 1, 0, 0, "run2"); tick();
    set_in(0, 0, 0, 16'h0000, 0, 0); expect_now(16'h0001, 0, 1, 0, 0, "at1_noce"); tick();
    set_in(0, 1, 0, 16'h0000, 0, 0); expect_now(16'h0001, 1, 1, 0, 0, "tc1"); tick();
    set_in(0, 0, 0, 16'h0000, 0, 0); expect_now(16'h0000, 0, 0, 1, 0, "done2"); tick();
    expect_now(16'h0000, 0, 0, 0, 0, "end_idle"); tick();
  endtask
`endif

  initial begin
    set_in(0, 0, 0, 16'h0000, 0, 0);
    tick();
    run_tests();
    repeat (2) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
